// File: rtl/btn_toggle_gen.sv
// rtl/btn_toggle_gen.sv - button synchroniser/debouncer emitting one toggle pulse per confirmed press
module btn_toggle_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PCNT_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_in,
  output logic              t,
  output logic              btn_level,
  output logic [PCNT_W-1:0] press_cnt
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic              s1_q, s2_q;
  logic [DB_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              t_q, t_d;
  logic              lvl_q, lvl_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  assign cnt_inc = cnt_q + DB_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    lvl_d   = lvl_q;
    pcnt_d  = pcnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s2_q) begin
          // With a single-sample debounce the first high sample is already confirmed.
          if (DB_LAST == DB_W'(1)) begin
            state_d = HELD;
            t_d     = 1'b1;
            lvl_d   = 1'b1;
            pcnt_d  = pcnt_q + PCNT_W'(1);
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = DB_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (s2_q) begin
          if (cnt_inc == DB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            t_d     = 1'b1;
            lvl_d   = 1'b1;
            pcnt_d  = pcnt_q + PCNT_W'(1);
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        cnt_d = '0;
        if (!s2_q) begin
          if (DB_LAST == DB_W'(1)) begin
            state_d = IDLE;
            lvl_d   = 1'b0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = DB_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (!s2_q) begin
          if (cnt_inc == DB_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            lvl_d   = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Bounce back to pressed: level never dropped, so no new pulse.
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      lvl_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      lvl_q   <= lvl_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign t         = t_q;
  assign btn_level = lvl_q;
  assign press_cnt = pcnt_q;

endmodule
